// File: rtl/dmem_bus_ctrl.sv
// dmem_bus_ctrl: registered data-memory bus master with alignment checks and a bus-wait watchdog.
// Loads read the whole bus word and extract the addressed lanes; stores enable only the addressed lanes.
module dmem_bus_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int TIMEOUT    = 1024,
  parameter int BIG_ENDIAN = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                en,
  input  logic [3:0]          op,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic [DATA_W-1:0]   d_writedata,
  output logic                stalled,
  output logic [DATA_W-1:0]   d_loadresult,
  output logic                d_valid,
  output logic [31:0]         ecause,
  output logic [ADDR_W-1:0]   bus_address,
  output logic [DATA_W/8-1:0] bus_byteen,
  output logic                bus_we,
  output logic                bus_en,
  output logic [DATA_W-1:0]   bus_writedata,
  input  logic [DATA_W-1:0]   bus_readdata,
  input  logic                bus_wait,
  input  logic [31:0]         bus_ecause
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = $clog2(TIMEOUT + 1) + 1;

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [OFF_W-1:0]  sh_q, sh_d, sh;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [DATA_W-1:0] res_q, res_d, wdata_q, wdata_d;
  logic [31:0]       ecause_q, ecause_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              we_q, we_d, ben_q, ben_d;
  logic [3:0]        nb;
  logic              misal, sgn;
  logic [DATA_W-1:0] rsh, lmask, ldata;

  function automatic logic [DATA_W-1:0] dmask(input logic [1:0] sz);
    return sz == 2'b11 ? DATA_W'(8'hFF) : sz == 2'b01 ? DATA_W'(16'hFFFF) :
           sz == 2'b00 ? DATA_W'(32'hFFFF_FFFF) : '1;
  endfunction

  function automatic logic [BE_W-1:0] bmask(input logic [1:0] sz);
    return sz == 2'b11 ? BE_W'(1'b1) : sz == 2'b01 ? BE_W'(2'b11) :
           sz == 2'b00 ? BE_W'(4'hF) : '1;
  endfunction

  assign nb    = op[1:0] == 2'b11 ? 4'd1 : op[1:0] == 2'b01 ? 4'd2 : op[1:0] == 2'b00 ? 4'd4 : 4'd8;
  assign misal = (op[1:0] == 2'b01 & d_address[0]) | (op[1:0] == 2'b00 & |d_address[1:0]) |
                 (op[1:0] == 2'b10 & ((DATA_W == 32) | |d_address[2:0]));
  // Byte shift of the access within the bus word; big-endian counts lanes from the MSB end
  assign sh    = BIG_ENDIAN != 0 ? OFF_W'(BE_W - int'(d_address[OFF_W-1:0]) - int'(nb))
                                 : d_address[OFF_W-1:0];

  assign rsh   = bus_readdata >> {sh_q, 3'b000};
  assign lmask = dmask(op_q[1:0]);
  assign sgn   = op_q[2] & (op_q[1:0] == 2'b11 ? rsh[7] : op_q[1:0] == 2'b01 ? rsh[15] :
                            op_q[1:0] == 2'b00 ? rsh[31] : 1'b0);
  assign ldata = (rsh & lmask) | (~lmask & {DATA_W{sgn}});

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sh_d     = sh_q;
    wcnt_d   = wcnt_q;
    res_d    = res_q;
    wdata_d  = wdata_q;
    ecause_d = ecause_q;
    addr_d   = addr_q;
    be_d     = be_q;
    we_d     = we_q;
    ben_d    = ben_q;
    case (state_q)
      IDLE: if (en) begin
        if (misal) begin
          state_d  = DONE;
          ecause_d = op[3] ? 32'd5 : 32'd4;
        end else begin
          state_d = BUS;
          ben_d   = 1'b1;
          we_d    = op[3];
          addr_d  = {d_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          be_d    = op[3] ? bmask(op[1:0]) << sh : '1;
          wdata_d = op[3] ? (d_writedata & dmask(op[1:0])) << {sh, 3'b000} : '0;
          op_d    = op[2:0];
          sh_d    = sh;
          wcnt_d  = '0;
        end
      end
      BUS: if (!bus_wait) begin
        ben_d    = 1'b0;
        state_d  = DONE;
        ecause_d = bus_ecause;
        res_d    = we_q ? res_q : ldata;
      end else if (TIMEOUT > 0 && wcnt_q == CNT_W'(TIMEOUT - 1)) begin
        ben_d    = 1'b0;
        state_d  = DONE;
        ecause_d = 32'd7;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      op_q     <= '0;
      sh_q     <= '0;
      wcnt_q   <= '0;
      res_q    <= '0;
      wdata_q  <= '0;
      ecause_q <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      ben_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sh_q     <= sh_d;
      wcnt_q   <= wcnt_d;
      res_q    <= res_d;
      wdata_q  <= wdata_d;
      ecause_q <= ecause_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      we_q     <= we_d;
      ben_q    <= ben_d;
    end
  end

  // Gated by resetn so the pipeline is released the instant reset asserts
  assign stalled       = resetn & ((state_q == IDLE & en) | state_q == BUS);
  assign d_valid       = state_q == DONE;
  assign d_loadresult  = res_q;
  assign ecause        = ecause_q;
  assign bus_address   = addr_q;
  assign bus_byteen    = be_q;
  assign bus_we        = we_q;
  assign bus_en        = ben_q;
  assign bus_writedata = wdata_q;
endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// tb_dmem_bus_ctrl: directed checks of a 32-bit big-endian and a 64-bit little-endian bus master.
module tb_dmem_bus_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        a_en = 0, a_stalled, a_dv, a_we, a_ben, a_wait = 0;
  logic [3:0]  a_op = 0, a_be;
  logic [31:0] a_addr = 0, a_wd = 0, a_res, a_ec, a_baddr, a_bwd, a_rd = 0, a_bec = 0;

  logic        b_en = 0, b_stalled, b_dv, b_we, b_ben, b_wait = 0;
  logic [3:0]  b_op = 0;
  logic [7:0]  b_be;
  logic [31:0] b_addr = 0, b_ec, b_baddr, b_bec = 0;
  logic [63:0] b_wd = 0, b_res, b_bwd, b_rd = 0;

  int n_chk = 0, n_fail = 0;

  dmem_bus_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(8), .BIG_ENDIAN(1)) u32 (
    .clk(clk), .resetn(resetn), .en(a_en), .op(a_op), .d_address(a_addr), .d_writedata(a_wd),
    .stalled(a_stalled), .d_loadresult(a_res), .d_valid(a_dv), .ecause(a_ec),
    .bus_address(a_baddr), .bus_byteen(a_be), .bus_we(a_we), .bus_en(a_ben),
    .bus_writedata(a_bwd), .bus_readdata(a_rd), .bus_wait(a_wait), .bus_ecause(a_bec));

  dmem_bus_ctrl #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(8), .BIG_ENDIAN(0)) u64 (
    .clk(clk), .resetn(resetn), .en(b_en), .op(b_op), .d_address(b_addr), .d_writedata(b_wd),
    .stalled(b_stalled), .d_loadresult(b_res), .d_valid(b_dv), .ecause(b_ec),
    .bus_address(b_baddr), .bus_byteen(b_be), .bus_we(b_we), .bus_en(b_ben),
    .bus_writedata(b_bwd), .bus_readdata(b_rd), .bus_wait(b_wait), .bus_ecause(b_bec));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    a_en = 1;
    repeat (2) @(negedge clk);
    chk("rst_stalled", a_stalled, 0);
    chk("rst_bus_en", a_ben, 0);
    chk("rst_dvalid", a_dv, 0);
    chk("rst_result", a_res, 0);
    chk("rst_ecause", a_ec, 0);
    chk("rst_b_bus_en", b_ben, 0);
    a_en = 0;
    resetn = 1;
    @(negedge clk);
    // LB 0x101, zero wait
    a_op = 4'b0111; a_addr = 32'h101; a_rd = 32'h8899AABB; a_en = 1;
    #1 chk("lb_stall_idle", a_stalled, 1);
    @(negedge clk);
    chk("lb_bus_en", a_ben, 1);
    chk("lb_byteen", a_be, 4'hF);
    chk("lb_addr", a_baddr, 32'h100);
    chk("lb_we", a_we, 0);
    chk("lb_dv_early", a_dv, 0);
    @(negedge clk);
    chk("lb_dvalid", a_dv, 1);
    chk("lb_result", a_res, 32'hFFFFFF99);
    chk("lb_stall_done", a_stalled, 0);
    chk("lb_bus_en_off", a_ben, 0);
    a_en = 0;
    @(negedge clk);
    chk("lb_dv_pulse", a_dv, 0);
    chk("lb_no_reaccept", a_ben, 0);
    // SH 0x1234 to 0x102 with 3 wait cycles
    a_op = 4'b1001; a_addr = 32'h102; a_wd = 32'hABCD1234; a_wait = 1; a_en = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("sh_bus_en", a_ben, 1);
      chk("sh_byteen", a_be, 4'h3);
      chk("sh_wdata", a_bwd, 32'h00001234);
      chk("sh_we", a_we, 1);
      chk("sh_addr", a_baddr, 32'h100);
      chk("sh_dv_early", a_dv, 0);
      if (i == 3) a_wait = 0;
    end
    @(negedge clk);
    chk("sh_dvalid", a_dv, 1);
    chk("sh_ecause", a_ec, 0);
    chk("sh_result_kept", a_res, 32'hFFFFFF99);
    a_en = 0;
    @(negedge clk);
    // Misaligned accesses
    a_op = 4'b0000; a_addr = 32'h102; a_en = 1;
    @(negedge clk);
    chk("lw_mis_dv", a_dv, 1);
    chk("lw_mis_ec", a_ec, 4);
    chk("lw_mis_bus_en", a_ben, 0);
    a_en = 0;
    @(negedge clk);
    a_op = 4'b1000; a_addr = 32'h101; a_en = 1;
    @(negedge clk);
    chk("sw_mis_dv", a_dv, 1);
    chk("sw_mis_ec", a_ec, 5);
    a_en = 0;
    @(negedge clk);
    a_op = 4'b0010; a_addr = 32'h100; a_en = 1;
    @(negedge clk);
    chk("ld32_mis_dv", a_dv, 1);
    chk("ld32_mis_ec", a_ec, 4);
    chk("ld32_bus_en", a_ben, 0);
    a_en = 0;
    @(negedge clk);
    // LHU 0x100 with slave error
    a_op = 4'b0001; a_addr = 32'h100; a_bec = 32'h12; a_en = 1;
    @(negedge clk);
    chk("lhu_bus_en", a_ben, 1);
    @(negedge clk);
    chk("lhu_dvalid", a_dv, 1);
    chk("lhu_result", a_res, 32'h00008899);
    chk("lhu_ecause", a_ec, 32'h12);
    a_en = 0; a_bec = 0;
    @(negedge clk);
    // Watchdog
    a_op = 4'b0000; a_addr = 32'h100; a_wait = 1; a_en = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("to_bus_en", a_ben, 1);
      chk("to_stalled", a_stalled, 1);
    end
    @(negedge clk);
    chk("to_bus_en_off", a_ben, 0);
    chk("to_dvalid", a_dv, 1);
    chk("to_ecause", a_ec, 7);
    chk("to_stalled_off", a_stalled, 0);
    chk("to_result_kept", a_res, 32'h00008899);
    a_en = 0; a_wait = 0;
    @(negedge clk);
    // Reset mid-access
    a_op = 4'b0111; a_addr = 32'h101; a_wait = 1; a_en = 1;
    @(negedge clk);
    chk("mr_bus_en", a_ben, 1);
    resetn = 0;
    #1;
    chk("mr_bus_en_off", a_ben, 0);
    chk("mr_stalled", a_stalled, 0);
    chk("mr_dvalid", a_dv, 0);
    chk("mr_ecause", a_ec, 0);
    chk("mr_result", a_res, 0);
    @(negedge clk);
    a_op = 4'b0011; a_addr = 32'h103; a_wait = 0;
    resetn = 1;
    @(negedge clk);
    chk("pr_bus_en", a_ben, 1);
    chk("pr_byteen", a_be, 4'hF);
    @(negedge clk);
    chk("pr_dvalid", a_dv, 1);
    chk("pr_result", a_res, 32'h000000BB);
    chk("pr_ecause", a_ec, 0);
    a_en = 0;
    @(negedge clk);
    // 64-bit little-endian: LD 0x08
    b_op = 4'b0010; b_addr = 32'h08; b_rd = 64'h0123456789ABCDEF; b_en = 1;
    @(negedge clk);
    chk("ld_bus_en", b_ben, 1);
    chk("ld_byteen", b_be, 8'hFF);
    chk("ld_addr", b_baddr, 32'h08);
    @(negedge clk);
    chk("ld_dvalid", b_dv, 1);
    chk("ld_result", b_res, 64'h0123456789ABCDEF);
    b_en = 0;
    @(negedge clk);
    b_op = 4'b0001; b_addr = 32'h0E; b_rd = 64'hBEEF111122223333; b_en = 1;
    @(negedge clk);
    chk("lhu64_addr", b_baddr, 32'h08);
    @(negedge clk);
    chk("lhu64_result", b_res, 64'h000000000000BEEF);
    b_en = 0;
    @(negedge clk);
    b_op = 4'b1011; b_addr = 32'h0D; b_wd = 64'hFFFFFFFFFFFFFF5A; b_en = 1;
    @(negedge clk);
    chk("sb64_byteen", b_be, 8'h20);
    chk("sb64_wdata", b_bwd, 64'h00005A0000000000);
    chk("sb64_we", b_we, 1);
    @(negedge clk);
    chk("sb64_dvalid", b_dv, 1);
    chk("sb64_result_kept", b_res, 64'h000000000000BEEF);
    b_en = 0;
    @(negedge clk);
    b_op = 4'b0100; b_addr = 32'h0C; b_rd = 64'h8000000012345678; b_en = 1;
    @(negedge clk);
    chk("lw64_byteen", b_be, 8'hFF);
    @(negedge clk);
    chk("lw64_result", b_res, 64'hFFFFFFFF80000000);
    b_en = 0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
